// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types, default sizes and select-width helper for the burst arbiter
package rr_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    localparam int DEF_NREQ   = 3;
    localparam int DEF_BEAT_W = 4;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search starting just above ptr, wrapping at NREQ
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int SEL_W = sel_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [NREQ-1:0] rot;

    // Bit 0 of rot is requester ptr+1; scanning downward lets the lowest set bit win.
    always_comb begin
        rot    = NREQ'({req, req} >> (int'(ptr) + 1));
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rot[i]) winner = SEL_W'((int'(ptr) + 1 + i) % NREQ);
    end

    assign any = |req;

endmodule

// File: rtl/rr_burst_grant_arbiter.sv
// rr_burst_grant_arbiter: round-robin arbiter holding a one-hot grant for a whole burst
// of req_beats+1 beats, with a one-cycle IDLE bubble between bursts.
module rr_burst_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int NREQ   = DEF_NREQ,
    parameter  int BEAT_W = DEF_BEAT_W,
    localparam int SEL_W  = sel_w(NREQ)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BEAT_W-1:0]   req_beats,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          grant,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy
);

    arb_state_e        state, state_next;
    logic [SEL_W-1:0]  rr_ptr, winner;
    logic [BEAT_W-1:0] beat_cnt;
    logic              any, fire;

    rr_pick #(.NREQ(NREQ), .SEL_W(SEL_W)) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any)
    );

    assign fire = busy & out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) state <= ARB_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ARB_IDLE) state_next = any ? ARB_LOCK : ARB_IDLE;
        else                   state_next = (fire && beat_cnt == '0) ? ARB_IDLE : ARB_LOCK;
    end

    // Burst length is captured only at grant time; later req_beats changes are ignored.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            grant    <= '0;
            out_sel  <= '0;
            beat_cnt <= '0;
            rr_ptr   <= SEL_W'(NREQ - 1);
        end else if (state == ARB_IDLE && any) begin
            grant    <= NREQ'(1) << winner;
            out_sel  <= winner;
            beat_cnt <= req_beats[int'(winner)*BEAT_W +: BEAT_W];
            rr_ptr   <= winner;
        end else if (fire) begin
            if (beat_cnt != '0) beat_cnt <= beat_cnt - 1'b1;
            else                grant    <= '0;
        end
    end

    always_comb begin
        busy      = (state == ARB_LOCK);
        out_valid = busy & req_valid[out_sel];
        req_ready = busy ? (grant & {NREQ{out_ready}}) : '0;
        out_last  = busy & (beat_cnt == '0);
    end

endmodule

// File: tb/tb_rr_burst_grant_arbiter.sv
// tb_rr_burst_grant_arbiter: directed scenarios plus a scored random stress run
module tb_rr_burst_grant_arbiter;
    import rr_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [11:0] req_beats;
    logic [2:0]  req_ready;
    logic [2:0]  grant;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int passes = 0;

    rr_burst_grant_arbiter #(.NREQ(3), .BEAT_W(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_beats (req_beats),
        .req_ready (req_ready),
        .grant     (grant),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_invariants;
        checks++;
        if (!$onehot0(grant) || (dut.state == ARB_IDLE && grant != 3'b000) ||
            ((req_ready & ~grant) != 3'b000) || (busy && grant[out_sel] !== 1'b1) ||
            busy !== (dut.state == ARB_LOCK))
            $display("FAIL invariants t=%0t grant=%b req_ready=%b out_sel=%0d busy=%b",
                     $time, grant, req_ready, out_sel, busy);
        else passes++;
    endtask

    task automatic sample;
        @(negedge clock);
        test_invariants();
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req_valid = '0; req_beats = '0; out_ready = 1'b0;
        tick(); tick(); sample();
        checks++;
        if ({grant, out_sel, out_valid, out_last, busy, req_ready} !== 12'h000)
            $display("FAIL reset_outputs got grant=%b sel=%0d valid=%b last=%b busy=%b ready=%b exp all 0",
                     grant, out_sel, out_valid, out_last, busy, req_ready);
        else passes++;
        checks++;
        if (dut.rr_ptr !== 2'd2) $display("FAIL reset_ptr got=%0d exp=2", dut.rr_ptr);
        else passes++;
        reset_n = 1'b1;
    endtask

    task automatic test_rr_single_beats;
        logic [2:0] exp_g;
        req_valid = 3'b111; req_beats = '0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = 3'b001 << (k % 3);
            tick(); sample();
            checks++;
            if (grant !== exp_g || out_sel !== 2'(k % 3) || out_last !== 1'b1 || req_ready !== exp_g)
                $display("FAIL rr_grant k=%0d got grant=%b sel=%0d last=%b ready=%b exp grant=%b",
                         k, grant, out_sel, out_last, req_ready, exp_g);
            else passes++;
            tick(); sample();
            checks++;
            if (grant !== 3'b000 || busy !== 1'b0)
                $display("FAIL rr_bubble k=%0d got grant=%b busy=%b exp 0/0", k, grant, busy);
            else passes++;
        end
        req_valid = '0;
    endtask

    task automatic test_burst_and_others;
        req_valid = 3'b010; req_beats = 12'h030; out_ready = 1'b1;
        tick(); sample();
        checks++;
        if (grant !== 3'b010) $display("FAIL burst_grant got=%b exp=010", grant);
        else passes++;
        req_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant !== 3'b010 || req_ready !== 3'b010 || out_valid !== 1'b1 || out_last !== (i == 3))
                $display("FAIL burst_beat i=%0d got grant=%b ready=%b valid=%b last=%b exp last=%0d",
                         i, grant, req_ready, out_valid, out_last, i == 3);
            else passes++;
            tick(); sample();
        end
        checks++;
        if (grant !== 3'b000) $display("FAIL burst_end got=%b exp=000", grant);
        else passes++;
        tick(); sample();
        checks++;
        if (grant !== 3'b100 || out_sel !== 2'd2)
            $display("FAIL after_burst_winner got grant=%b sel=%0d exp 100/2", grant, out_sel);
        else passes++;
        tick(); sample();
        checks++;
        if (grant !== 3'b000) $display("FAIL req2_single_beat got=%b exp=000", grant);
        else passes++;
        req_valid = '0;
    endtask

    task automatic test_stall;
        int fires = 0;
        req_valid = 3'b010; req_beats = 12'h030; out_ready = 1'b1;
        tick(); sample();
        checks++;
        if (grant !== 3'b010) $display("FAIL stall_grant got=%b exp=010", grant);
        else passes++;
        tick(); sample();
        req_valid = 3'b000;
        for (int j = 0; j < 5; j++) begin
            tick(); sample();
            checks++;
            if (grant !== 3'b010 || dut.beat_cnt !== 4'd2 || out_valid !== 1'b0)
                $display("FAIL stall_novalid j=%0d got grant=%b cnt=%0d valid=%b exp 010/2/0",
                         j, grant, dut.beat_cnt, out_valid);
            else passes++;
        end
        req_valid = 3'b010; out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick(); sample();
            checks++;
            if (grant !== 3'b010 || dut.beat_cnt !== 4'd2 || req_ready !== 3'b000)
                $display("FAIL stall_noready j=%0d got grant=%b cnt=%0d ready=%b exp 010/2/000",
                         j, grant, dut.beat_cnt, req_ready);
            else passes++;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && grant != 3'b000; c++) begin
            if (out_valid && out_ready) begin
                fires++;
                checks++;
                if (out_last !== (fires == 3))
                    $display("FAIL stall_last fire=%0d got=%b exp=%0d", fires, out_last, fires == 3);
                else passes++;
            end
            tick(); sample();
        end
        checks++;
        if (fires != 3 || grant !== 3'b000)
            $display("FAIL stall_fire_count got=%0d grant=%b exp 3/000", fires, grant);
        else passes++;
        req_valid = '0;
    endtask

    task automatic test_reset_mid_burst;
        req_valid = 3'b010; req_beats = 12'h030; out_ready = 1'b1;
        tick(); sample();
        tick(); sample();
        checks++;
        if (grant !== 3'b010 || dut.beat_cnt !== 4'd2)
            $display("FAIL midrst_pre got grant=%b cnt=%0d exp 010/2", grant, dut.beat_cnt);
        else passes++;
        reset_n = 1'b0; req_valid = 3'b111;
        tick(); sample();
        checks++;
        if ({grant, out_sel, out_valid, out_last, busy, req_ready} !== 12'h000)
            $display("FAIL midrst_outputs got grant=%b sel=%0d valid=%b last=%b busy=%b ready=%b exp all 0",
                     grant, out_sel, out_valid, out_last, busy, req_ready);
        else passes++;
        reset_n = 1'b1;
        tick(); sample();
        checks++;
        if (grant !== 3'b001) $display("FAIL midrst_winner got=%b exp=001", grant);
        else passes++;
        tick(); sample();
        req_valid = '0;
    endtask

    task automatic test_stress;
        logic [2:0]  prev_valid;
        logic [11:0] prev_beats;
        logic        prev_busy;
        int ptr_m = 0, exp_w, exp_len = 0, fires = 0;
        prev_valid = req_valid; prev_beats = req_beats; prev_busy = busy;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                req_beats[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            sample();
            if (busy && !prev_busy) begin
                exp_w = -1;
                for (int k = 1; k <= 3; k++)
                    if (exp_w < 0 && prev_valid[(ptr_m + k) % 3]) exp_w = (ptr_m + k) % 3;
                checks++;
                if (exp_w < 0 || out_sel !== 2'(exp_w))
                    $display("FAIL stress_winner cyc=%0d got=%0d exp=%0d", cyc, out_sel, exp_w);
                else passes++;
                if (exp_w >= 0) begin
                    ptr_m = exp_w;
                    exp_len = int'(prev_beats[exp_w*4 +: 4]) + 1;
                end
                fires = 0;
            end
            if (busy && out_valid && out_ready) begin
                fires++;
                if (out_last) begin
                    checks++;
                    if (fires != exp_len)
                        $display("FAIL stress_burst_len cyc=%0d got=%0d exp=%0d", cyc, fires, exp_len);
                    else passes++;
                end
            end
            prev_busy = busy; prev_valid = req_valid; prev_beats = req_beats;
        end
    endtask

    initial begin
        test_reset();
        test_rr_single_beats();
        test_burst_and_others();
        test_stall();
        test_reset_mid_burst();
        test_stress();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
